// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton/LED bank.
// Covers the LED mode encodings and the counter width helper.
package button_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TOGGLE                  = 2'd0;
  localparam mode_t MODE_MOMENTARY               = 2'd1;
  localparam mode_t MODE_LONG_TOGGLE             = 2'd2;
  localparam mode_t MODE_SHORT_TOGGLE_LONG_CLEAR = 2'd3;

  // Bits needed for a counter that must be able to hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: debounce filter, hold timer, press/long-press pulses
// and LED drive in the selected mode.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  button,
  input  mode_t mode,
  output logic  led,
  output logic  press_pulse,
  output logic  long_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LP_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] LP_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          db;
  logic          db_next;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_next;
  logic [HW-1:0] hcnt;
  logic          press_evt;
  logic          release_evt;
  logic          long_evt;
  logic          short_release;
  logic          led_next;

  // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    db_next   = db;
    dcnt_next = '0;
    if (button != db) begin
      if (dcnt == DB_LAST) begin
        db_next = button;
      end else begin
        dcnt_next = dcnt + 1'b1;
      end
    end
  end

  assign press_evt     = !db && db_next;
  assign release_evt   = db && !db_next;
  // hcnt saturates at LP_MAX, so this can only fire once per hold.
  assign long_evt      = db && db_next && (hcnt == LP_LAST);
  assign short_release = release_evt && (hcnt != LP_MAX);

  always_comb begin
    led_next = led;
    unique case (mode)
      MODE_TOGGLE: begin
        if (press_evt) led_next = !led;
      end
      MODE_MOMENTARY: begin
        led_next = db_next;
      end
      MODE_LONG_TOGGLE: begin
        if (long_evt) led_next = !led;
      end
      MODE_SHORT_TOGGLE_LONG_CLEAR: begin
        if (long_evt) begin
          led_next = 1'b0;
        end else if (short_release) begin
          led_next = !led;
        end
      end
      default: led_next = led;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db          <= 1'b0;
      dcnt        <= '0;
      hcnt        <= '0;
      led         <= 1'b0;
      press_pulse <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      db          <= db_next;
      dcnt        <= dcnt_next;
      led         <= led_next;
      press_pulse <= press_evt;
      long_press  <= long_evt;
      if (press_evt) begin
        hcnt <= '0;
      end else if (db && db_next && (hcnt != LP_MAX)) begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_toggle_bank.sv
// Bank of independent debounced pushbutton channels sharing clock, reset and
// the global LED mode.
module button_toggle_bank
  import button_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] button,
  input  mode_t             mode,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] long_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .button     (button[i]),
      .mode       (mode),
      .led        (led[i]),
      .press_pulse(press_pulse[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_toggle_bank.sv
// Directed plus randomized bench for button_toggle_bank, checked against a
// per-channel behavioural model of debounce, hold timing and LED modes.
module tb_button_toggle_bank;
  import button_pkg::*;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LP = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] button;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [N-1:0] press_pulse;
  logic [N-1:0] long_press;

  int errors = 0;
  int checks = 0;

  // Model: run of differing samples, debounced level, edges since press.
  int m_run   [N];
  bit m_db    [N];
  int m_since [N];
  bit m_led   [N];
  bit m_pp    [N];
  bit m_lp    [N];

  always #5 clk = ~clk;

  button_toggle_bank #(
    .NUM_CH           (N),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button     (button),
    .mode       (mode),
    .led        (led),
    .press_pulse(press_pulse),
    .long_press (long_press)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c]   = 0;
      m_db[c]    = 1'b0;
      m_since[c] = 0;
      m_led[c]   = 1'b0;
      m_pp[c]    = 1'b0;
      m_lp[c]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit was_high = m_db[c];
      bit now_high = m_db[c];
      bit pressed;
      bit released;
      bit went_long = 1'b0;
      bit was_short;
      if (button[c] != was_high) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DB) begin
          now_high = button[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      pressed   = !was_high && now_high;
      released  = was_high && !now_high;
      was_short = released && (m_since[c] < LP);
      if (pressed) begin
        m_since[c] = 0;
      end else if (was_high && now_high) begin
        m_since[c] = m_since[c] + 1;
        went_long  = (m_since[c] == LP);
      end
      case (mode)
        2'd0: if (pressed) m_led[c] = !m_led[c];
        2'd1: m_led[c] = now_high;
        2'd2: if (went_long) m_led[c] = !m_led[c];
        default: begin
          if (went_long) m_led[c] = 1'b0;
          else if (was_short) m_led[c] = !m_led[c];
        end
      endcase
      m_db[c] = now_high;
      m_pp[c] = pressed;
      m_lp[c] = went_long;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_led;
    logic [N-1:0] e_pp;
    logic [N-1:0] e_lp;
    for (int c = 0; c < N; c++) begin
      e_led[c] = m_led[c];
      e_pp[c]  = m_pp[c];
      e_lp[c]  = m_lp[c];
    end
    chk("model_led", led, e_led);
    chk("model_press_pulse", press_pulse, e_pp);
    chk("model_long_press", long_press, e_lp);
  endtask

  task automatic cyc(input logic [N-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      button = b;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end
  endtask

  initial begin
    logic [N-1:0] rb;
    logic [7:0]   glitch;

    reset  = 1'b1;
    button = '0;
    mode   = MODE_TOGGLE;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", led, 2'b00);
    chk("reset_press", press_pulse, 2'b00);
    chk("reset_long", long_press, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // Mode 0: short blip rejected, then two full presses toggle led[0].
    cyc(2'b01, 3);
    cyc(2'b00, 2);
    chk("blip_led", led, 2'b00);
    cyc(2'b01, 4);
    chk("toggle_press_edge4", press_pulse, 2'b01);
    cyc(2'b01, 6);
    chk("toggle_led_on", led, 2'b01);
    cyc(2'b00, 6);
    cyc(2'b01, 10);
    cyc(2'b00, 6);
    chk("toggle_led_off", led, 2'b00);

    // Glitchy button[1] never debounces.
    glitch = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      cyc({glitch[i], 1'b0}, 1);
      chk("glitch_no_press", press_pulse, 2'b00);
    end
    cyc(2'b00, 4);

    // Mode 2: long hold toggles once at edge 20, short hold ignored.
    mode = MODE_LONG_TOGGLE;
    cyc(2'b01, 4);
    chk("long_press_edge4", press_pulse, 2'b01);
    cyc(2'b01, 15);
    chk("long_not_yet", long_press, 2'b00);
    cyc(2'b01, 1);
    chk("long_edge20", long_press, 2'b01);
    chk("long_led_toggle", led, 2'b01);
    cyc(2'b01, 10);
    chk("long_once", long_press, 2'b00);
    cyc(2'b00, 6);
    cyc(2'b01, 10);
    cyc(2'b00, 6);
    chk("long_short_ignored", led, 2'b01);

    // Mode 1 with buttons released clears the LEDs.
    mode = MODE_MOMENTARY;
    cyc(2'b00, 1);
    chk("momentary_clear", led, 2'b00);

    // Mode 3: short release toggles, long press clears, its release no toggle.
    mode = MODE_SHORT_TOGGLE_LONG_CLEAR;
    cyc(2'b01, 10);
    cyc(2'b00, 3);
    chk("short_before_release", led, 2'b00);
    cyc(2'b00, 1);
    chk("short_release_toggle", led, 2'b01);
    cyc(2'b00, 2);
    cyc(2'b01, 20);
    chk("long_clear", led, 2'b00);
    cyc(2'b01, 5);
    cyc(2'b00, 6);
    chk("long_release_no_toggle", led, 2'b00);

    // Mode 1 on both channels, then switch to mode 0 while held.
    mode = MODE_MOMENTARY;
    cyc(2'b11, 8);
    chk("momentary_both", led, 2'b11);
    mode = MODE_TOGGLE;
    cyc(2'b11, 3);
    chk("leave_momentary_keep", led, 2'b11);
    cyc(2'b00, 6);

    // Asynchronous reset mid-cycle while button[0] is held.
    cyc(2'b01, 6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_led", led, 2'b00);
    chk("async_press", press_pulse, 2'b00);
    chk("async_long", long_press, 2'b00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(2'b01, 3);
    chk("post_reset_no_press", press_pulse, 2'b00);
    cyc(2'b01, 1);
    chk("post_reset_press", press_pulse, 2'b01);
    cyc(2'b00, 6);

    // Randomized phase: slowly varying buttons with occasional mode changes.
    rb = '0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) rb[c] = ~rb[c];
      end
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      cyc(rb, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_toggle_bank.md
Name: button_toggle_bank

Overview:
- Bank of NUM_CH independent pushbutton channels. Each channel debounces its button, detects press, release and long-press events, and drives an LED output according to a selectable mode.
- Sits between already-synchronized board pushbuttons and the LED/status outputs.
- Successor to the single-channel press-toggles-LED block. Adds:
  - parametrised channel count;
  - debounce filtering;
  - long-press detection;
  - four LED modes.

Parameters:
- NUM_CH, 4, number of independent button/LED channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive differing samples required before the debounced level changes (>=1).
- LONG_PRESS_CYCLES, 16, cycles the debounced level must stay high after a press to raise a long-press event (>=2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- button  input  NUM_CH  raw pushbutton levels, already synchronized to clk; 1 = pressed.
- mode  input  2  global LED mode, sampled every edge: 0 toggle, 1 momentary, 2 long-toggle, 3 short-toggle/long-clear.
- led  output reg  NUM_CH  LED drive per channel.
- press_pulse  output reg  NUM_CH  one-cycle pulse per debounced press.
- long_press  output reg  NUM_CH  one-cycle pulse per long press.

Behaviour:
- Reset: led, press_pulse, long_press, debounced level db, debounce counter and hold counter are all 0 in every channel.
  - Takes effect immediately, including mid-debounce or mid-hold.
  - After reset deasserts, a button already held high is treated as a new press once debounced.
- Debounce, per channel, each edge:
  - If button == db, clear dcnt.
  - Otherwise increment dcnt. When the increment would reach DEBOUNCE_CYCLES, db <= button and dcnt <= 0.
  - Result: db changes on the DEBOUNCE_CYCLES-th consecutive edge at which button != db.
  - Any single matching sample restarts the count.
  - With DEBOUNCE_CYCLES = 1, db simply lags button by one cycle.
- Press: the edge where db goes 0->1. press_pulse is high for exactly the following cycle, and hcnt <= 0.
- Hold: each edge with db = 1 after the press edge, hcnt increments, saturating at LONG_PRESS_CYCLES.
  - long_press is high for exactly one cycle, at the edge where hcnt becomes LONG_PRESS_CYCLES.
  - That is, LONG_PRESS_CYCLES edges after the press edge.
  - At most one long_press per hold.
- Release: the edge where db goes 1->0. It is "short" if hcnt < LONG_PRESS_CYCLES at that edge.
- LED update, same edge as the triggering event, no extra latency:
  - mode 0: led toggles on each press.
  - mode 1: led <= db every edge.
  - mode 2: led toggles on each long_press event only; short presses are ignored.
  - mode 3: led toggles on each short release; led <= 0 on a long_press event.
- Mode changes: take effect on the next edge.
  - Switching into mode 1 forces led = db on that edge.
  - Switching away from mode 1 retains the current led value.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(LONG_PRESS_CYCLES+1).
- Channels are fully independent: simultaneous events on several channels are all honoured in the same cycle.
- press_pulse and long_press never assert together. Guaranteed because LONG_PRESS_CYCLES >= 2.

Decomposition:
- Shared package button_pkg:
  - mode localparams MODE_TOGGLE = 2'd0, MODE_MOMENTARY = 2'd1, MODE_LONG_TOGGLE = 2'd2, MODE_SHORT_TOGGLE_LONG_CLEAR = 2'd3;
  - counter-width helper constants.
- Sub-module button_channel: one channel's debounce, hold counter, event pulses and LED logic.
- Top level: generate loop instantiating NUM_CH copies of button_channel, with clk, reset and mode shared.

Test Plan (NUM_CH=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16):
- Reset: assert reset asynchronously mid-cycle -> led, press_pulse, long_press all 2'b00 immediately; assert reset while button[0] is held -> after release of reset, press_pulse[0] fires 4 edges later.
- Mode 0 toggle: button[0] high for 3 cycles then low -> no pulse, led[0] = 0; button[0] high for 10 cycles -> press_pulse[0] high one cycle after the 4th edge, led[0] = 1; second 10-cycle press -> led[0] = 0; led[1] stays 0 throughout.
- Glitch rejection: button[1] pattern 1,1,1,0,1,1,1,0 -> db never changes, no pulses.
- Mode 2 long-toggle: hold button[0] for 30 cycles -> press_pulse at edge 4, long_press at edge 20 only once, led[0] toggles at edge 20 only; a 10-cycle hold -> led[0] unchanged.
- Mode 3: 10-cycle hold then release -> led[0] toggles to 1 at the debounced release; 30-cycle hold -> led[0] cleared to 0 at the long_press edge, release causes no toggle.
- Mode 1 and concurrency: both buttons held for 8 cycles in mode 1 -> led tracks db on both channels simultaneously; switch to mode 0 while held -> led stays 2'b11.
